// File: rtl/reload_pkg.sv
// reload_pkg: shared defaults, count type and terminal-count helper for reload_queue
package reload_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 4;
  typedef logic [WIDTH_DEF-1:0] cnt_t;
  function automatic logic is_terminal(cnt_t count);
    return count == '1;
  endfunction
endpackage

// File: rtl/reload_queue_sync_fifo.sv
// sync_fifo: power-of-two FIFO with combinational head read
// Ports: push/wdata enqueue, pop advances head, rdata = head, level/empty/full decodes.
module sync_fifo
  import reload_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [LW-1:0]    r_level;
  // pointers wrap for free because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (push) r_wp <= r_wp + 1'b1;
      if (pop) r_rp <= r_rp + 1'b1;
      r_level <= r_level + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp] <= wdata;
  end
  assign rdata = r_mem[r_rp];
  assign level = r_level;
  assign empty = r_level == '0;
  assign full  = r_level == LW'(DEPTH);
endmodule

// File: rtl/reload_queue.sv
// reload_queue: buffers counter reload values and issues one per terminal count
// Ports: wr_valid_i/wr_data_i/wr_ready_o producer handshake, count_i observed count,
// sticky_i reuse last value when empty, load_o/load_val_o to counter, level_o/empty_o/full_o status.
module reload_queue
  import reload_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_valid_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic                   wr_ready_o,
  input  logic [WIDTH-1:0]       count_i,
  input  logic                   sticky_i,
  output logic                   load_o,
  output logic [WIDTH-1:0]       load_val_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   empty_o,
  output logic                   full_o
);
  logic             w_term;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] r_last_val;
  logic             r_last_valid;
  assign w_term = &count_i;
  assign w_push = wr_valid_i && !w_full;
  // a sticky reissue never pops, so pop needs real data
  assign w_pop  = load_o && !w_empty;
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .wdata   (wr_data_i),
    .rdata   (w_head),
    .level   (level_o),
    .empty   (w_empty),
    .full    (w_full)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_val   <= '0;
      r_last_valid <= 1'b0;
    end else if (w_pop) begin
      r_last_val   <= w_head;
      r_last_valid <= 1'b1;
    end
  end
  always_comb begin
    load_o     = w_term && (!w_empty || (sticky_i && r_last_valid));
    load_val_o = !w_empty ? w_head : sticky_i ? r_last_val : '0;
  end
  assign wr_ready_o = !w_full;
  assign empty_o    = w_empty;
  assign full_o     = w_full;
endmodule

// File: tb/tb_reload_queue.sv
// tb_reload_queue: directed stimulus against a queue-based model of reload_queue
module tb_reload_queue;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_valid_i;
  logic [3:0] wr_data_i;
  logic       wr_ready_o;
  logic [3:0] count_i;
  logic       sticky_i;
  logic       load_o;
  logic [3:0] load_val_o;
  logic [2:0] level_o;
  logic       empty_o;
  logic       full_o;
  int checks = 0;
  int errors = 0;
  int q[$];
  int m_last;
  bit m_lv;
  always #5 clk = ~clk;
  reload_queue dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_valid_i (wr_valid_i),
    .wr_data_i  (wr_data_i),
    .wr_ready_o (wr_ready_o),
    .count_i    (count_i),
    .sticky_i   (sticky_i),
    .load_o     (load_o),
    .load_val_o (load_val_o),
    .level_o    (level_o),
    .empty_o    (empty_o),
    .full_o     (full_o)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", n, a, e);
    end
  endtask
  function automatic int exp_load();
    return 32'((count_i == 4'hF) && (q.size() > 0 || (sticky_i && m_lv)));
  endfunction
  function automatic int exp_val();
    return q.size() > 0 ? q[0] : sticky_i ? m_last : 0;
  endfunction
  task automatic model_clear();
    q.delete();
    m_last = 0;
    m_lv = 0;
  endtask
  task automatic model_edge();
    bit pop;
    bit push;
    if (!reset_n) return;
    pop  = (count_i == 4'hF) && q.size() > 0;
    push = wr_valid_i && q.size() < 4;
    if (pop) begin
      m_last = q[0];
      m_lv = 1;
      void'(q.pop_front());
    end
    if (push) q.push_back(int'(wr_data_i));
  endtask
  always @(negedge clk) begin
    chk("ready", 32'(wr_ready_o), 32'(q.size() < 4));
    chk("load", 32'(load_o), exp_load());
    chk("load_val", 32'(load_val_o), exp_val());
    chk("level", 32'(level_o), q.size());
    chk("empty", 32'(empty_o), 32'(q.size() == 0));
    chk("full", 32'(full_o), 32'(q.size() == 4));
  end
  task automatic drive(input bit wv, input int wd, input int cnt, input bit st);
    @(posedge clk);
    model_edge();
    #1;
    wr_valid_i = wv;
    wr_data_i  = 4'(wd);
    count_i    = 4'(cnt);
    sticky_i   = st;
  endtask
  initial begin
    reset_n = 1'b0;
    wr_valid_i = 1'b0;
    wr_data_i = '0;
    count_i = '0;
    sticky_i = 1'b0;
    model_clear();
    #2;
    chk("rst_load", 32'(load_o), 0);
    chk("rst_ready", 32'(wr_ready_o), 1);
    chk("rst_empty", 32'(empty_o), 1);
    #10 reset_n = 1'b1;
    for (int c = 0; c < 16; c++) drive(0, 0, c, 0);
    @(negedge clk);
    chk("idle_load15", 32'(load_o), 0);
    drive(1, 3, 0, 0);
    drive(1, 7, 0, 0);
    drive(1, 9, 0, 0);
    drive(0, 0, 15, 0);
    @(negedge clk);
    chk("seq_level3", 32'(level_o), 3);
    chk("seq_val3", 32'(load_val_o), 3);
    drive(0, 0, 0, 0);
    drive(0, 0, 15, 0);
    @(negedge clk);
    chk("seq_level2", 32'(level_o), 2);
    chk("seq_val7", 32'(load_val_o), 7);
    drive(0, 0, 0, 0);
    drive(0, 0, 15, 0);
    @(negedge clk);
    chk("seq_val9", 32'(load_val_o), 9);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("seq_level0", 32'(level_o), 0);
    for (int i = 10; i < 15; i++) drive(1, i, 0, 0);
    @(negedge clk);
    chk("full_flag", 32'(full_o), 1);
    chk("full_ready", 32'(wr_ready_o), 0);
    drive(1, 14, 15, 0);
    @(negedge clk);
    chk("full_pop_val", 32'(load_val_o), 10);
    chk("full_pop_ready", 32'(wr_ready_o), 0);
    drive(1, 14, 0, 0);
    @(negedge clk);
    chk("after_pop_level", 32'(level_o), 3);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("held_accepted", 32'(level_o), 4);
    for (int i = 0; i < 4; i++) drive(0, 0, 15, 0);
    drive(0, 0, 0, 0);
    drive(1, 4, 0, 0);
    drive(0, 0, 15, 1);
    drive(0, 0, 15, 1);
    @(negedge clk);
    chk("sticky_load", 32'(load_o), 1);
    chk("sticky_val", 32'(load_val_o), 4);
    chk("sticky_level", 32'(level_o), 0);
    drive(0, 0, 15, 0);
    @(negedge clk);
    chk("nosticky_load", 32'(load_o), 0);
    drive(1, 2, 0, 0);
    drive(1, 6, 15, 0);
    @(negedge clk);
    chk("pp_val", 32'(load_val_o), 2);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("pp_level", 32'(level_o), 1);
    chk("pp_head", 32'(load_val_o), 6);
    drive(0, 0, 15, 0);
    drive(1, 8, 15, 0);
    @(negedge clk);
    chk("nobypass_load", 32'(load_o), 0);
    drive(0, 0, 15, 0);
    @(negedge clk);
    chk("nobypass_next", 32'(load_val_o), 8);
    drive(0, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 2, 0, 0);
    drive(0, 0, 15, 1);
    @(posedge clk);
    model_edge();
    #3;
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("async_load", 32'(load_o), 0);
    chk("async_val", 32'(load_val_o), 0);
    chk("async_level", 32'(level_o), 0);
    chk("async_empty", 32'(empty_o), 1);
    chk("async_full", 32'(full_o), 0);
    chk("async_ready", 32'(wr_ready_o), 1);
    #3 reset_n = 1'b1;
    drive(0, 0, 15, 1);
    @(negedge clk);
    chk("post_rst_sticky", 32'(load_o), 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
